// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo serial receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Counter must be able to hold the value width (one past the last bit index).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-word output holding register for sipo: data, parity flag and valid.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             load_perr,
  input  logic             consume,
  output logic [width-1:0] data_o,
  output logic             valid_out,
  output logic             parity_err,
  output logic             will_empty
);

  // Buffer is free this edge if it holds nothing or its word is being taken.
  assign will_empty = !valid_out || consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= '0;
      valid_out  <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      data_o     <= load_data;
      parity_err <= load_perr;
      valid_out  <= 1'b1;
    end else if (valid_out && consume) begin
      valid_out  <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out receiver, MSB first, valid/ready on both sides.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo
  import sipo_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk_rx_in,
  input  logic             rst,
  input  logic             data_i,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [width-1:0] data_o,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             parity_err
);

  localparam int CW = cnt_width(width);

  state_t           r_state, w_next;
  logic [width-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_bit_xfer;
  logic             w_last_bit;
  logic             w_will_empty;
  logic             w_load;
  logic [width-1:0] w_load_data;
  logic             w_load_perr;
`ifdef SIPO_PARITY_EN
  logic             r_perr;
`endif

  assign ready_out  = rst && (r_state != FULL);
  assign w_bit_xfer = valid_in && ready_out;
  assign w_last_bit = (r_cnt == CW'(width - 1));

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = r_shift;
`ifdef SIPO_PARITY_EN
    w_load_perr = r_perr;
`else
    w_load_perr = 1'b0;
`endif
    case (r_state)
      COLLECT: begin
        if (w_bit_xfer && w_last_bit) begin
`ifdef SIPO_PARITY_EN
          w_next = PARITY;
`else
          w_load_data = {r_shift[width-2:0], data_i};
          if (w_will_empty) begin
            w_load = 1'b1;
            w_next = COLLECT;
          end else begin
            w_next = FULL;
          end
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (w_bit_xfer) begin
          w_load_perr = (^r_shift) ^ data_i;
          if (w_will_empty) begin
            w_load = 1'b1;
            w_next = COLLECT;
          end else begin
            w_next = FULL;
          end
        end
      end
`endif
      FULL: begin
        if (w_will_empty) begin
          w_load = 1'b1;
          w_next = COLLECT;
        end
      end
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk_rx_in or negedge rst) begin
    if (!rst) begin
      r_state <= COLLECT;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Parity bit is counted by state, not shifted, so data_o never sees it.
      if (w_bit_xfer && r_state == COLLECT)
        r_shift <= {r_shift[width-2:0], data_i};
      if (w_load)
        r_cnt <= '0;
      else if (w_bit_xfer && r_state == COLLECT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk_rx_in or negedge rst) begin
    if (!rst)
      r_perr <= 1'b0;
    else if (w_bit_xfer && r_state == PARITY)
      r_perr <= w_load_perr;
  end
`endif

  sipo_out_buf #(
    .width(width)
  ) u_out_buf (
    .clk        (clk_rx_in),
    .rst_n      (rst),
    .load       (w_load),
    .load_data  (w_load_data),
    .load_perr  (w_load_perr),
    .consume    (ready_in),
    .data_o     (data_o),
    .valid_out  (valid_out),
    .parity_err (parity_err),
    .will_empty (w_will_empty)
  );

endmodule
